// File: rtl/sfm_pkg.sv
// Shared constants and lane request type for the softmax TCDM lane synchroniser.
package sfm_pkg;

   localparam int unsigned SFM_TCDM_LANE_W = 32;

   typedef struct packed {
      logic [SFM_TCDM_LANE_W-1:0]   add;
      logic [SFM_TCDM_LANE_W/8-1:0] be;
      logic [SFM_TCDM_LANE_W-1:0]   data;
   } sfm_lane_req_t;

endpackage

// File: rtl/sfm_tcdm_lane_fifo.sv
// Per-lane response FIFO: holds beats that arrive before the other lanes catch up.
module sfm_tcdm_lane_fifo
   import sfm_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [SFM_TCDM_LANE_W-1:0] i_data,
   output logic [SFM_TCDM_LANE_W-1:0] o_data,
   output logic                       o_empty,
   output logic                       o_full
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [SFM_TCDM_LANE_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]              r_rd;
   logic [PW-1:0]              r_wr;
   logic [CW-1:0]              r_cnt;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_wr <= f_inc(r_wr);
         if (i_pop)  r_rd <= f_inc(r_rd);
         if (i_push && !i_pop)      r_cnt <= r_cnt + 1'b1;
         else if (i_pop && !i_push) r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wr] <= i_data;
   end

   assign o_data  = r_mem[r_rd];
   assign o_empty = (r_cnt == '0);
   assign o_full  = (r_cnt == CW'(DEPTH));

   // Issue throttling upstream must keep every lane within DEPTH beats.
   always_ff @(posedge i_clk) begin
      if (i_rst_n) assert (!(i_push && o_full && !i_pop));
   end

endmodule

// File: rtl/sfm_tcdm_lane_sync.sv
// Joins MP independent TCDM lanes into one atomic wide grant/response.
// Optional stall counter: define SFM_TCDM_LANE_SYNC_PERF_EN.
module sfm_tcdm_lane_sync
   import sfm_pkg::*;
#(
   parameter int unsigned MP    = 4,
   parameter int unsigned DEPTH = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 in_req_i,
   output logic                                 in_gnt_o,
   input  logic [MP-1:0][SFM_TCDM_LANE_W-1:0]   in_add_i,
   input  logic                                 in_wen_i,
   input  logic [MP-1:0][SFM_TCDM_LANE_W/8-1:0] in_be_i,
   input  logic [MP-1:0][SFM_TCDM_LANE_W-1:0]   in_data_i,
   output logic [MP-1:0][SFM_TCDM_LANE_W-1:0]   in_r_data_o,
   output logic                                 in_r_valid_o,
   output logic [MP-1:0]                        out_req_o,
   input  logic [MP-1:0]                        out_gnt_i,
   output logic [MP-1:0][SFM_TCDM_LANE_W-1:0]   out_add_o,
   output logic [MP-1:0]                        out_wen_o,
   output logic [MP-1:0][SFM_TCDM_LANE_W/8-1:0] out_be_o,
   output logic [MP-1:0][SFM_TCDM_LANE_W-1:0]   out_data_o,
   input  logic [MP-1:0][SFM_TCDM_LANE_W-1:0]   out_r_data_i,
   input  logic [MP-1:0]                        out_r_valid_i,
   input  logic                                 perf_clr_i,
   output logic [31:0]                          perf_stall_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [MP-1:0] r_done;
   logic [CW-1:0] r_cnt;
   logic          w_room;
   logic [MP-1:0] w_nempty;
   logic [MP-1:0] w_empty;
   logic [MP-1:0] w_full;
   logic [MP-1:0] w_push;
   logic [MP-1:0] w_pop;
   logic          w_unused;

   logic [SFM_TCDM_LANE_W-1:0] w_head [MP];
   sfm_lane_req_t              w_lreq [MP];

   assign w_room    = (r_cnt < CW'(DEPTH));
   assign out_req_o = {MP{in_req_i & w_room}} & ~r_done;
   assign in_gnt_o  = in_req_i & w_room & (&(r_done | out_gnt_i));

   assign w_nempty     = ~w_empty;
   assign in_r_valid_o = &(w_nempty | out_r_valid_i);
   assign out_wen_o    = {MP{in_req_i & in_wen_i}};

   for (genvar i = 0; i < MP; i++) begin : g_lane
      assign w_lreq[i] = in_req_i ?
         sfm_lane_req_t'{add: in_add_i[i], be: in_be_i[i], data: in_data_i[i]} :
         '0;
      assign out_add_o[i]  = w_lreq[i].add;
      assign out_be_o[i]   = w_lreq[i].be;
      assign out_data_o[i] = w_lreq[i].data;

      // A live beat is stored only if it cannot bypass straight upstream.
      assign w_pop[i]  = in_r_valid_o & w_nempty[i];
      assign w_push[i] = out_r_valid_i[i] & ~(in_r_valid_o & w_empty[i]);

      assign in_r_data_o[i] = !in_r_valid_o ? '0 :
                              w_nempty[i]   ? w_head[i] :
                                              out_r_data_i[i];

      sfm_tcdm_lane_fifo #(.DEPTH(DEPTH)) u_fifo (
         .i_clk   (clk_i),
         .i_rst_n (rst_ni),
         .i_push  (w_push[i]),
         .i_pop   (w_pop[i]),
         .i_data  (out_r_data_i[i]),
         .o_data  (w_head[i]),
         .o_empty (w_empty[i]),
         .o_full  (w_full[i])
      );
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_done <= '0;
         r_cnt  <= '0;
      end else begin
         if (in_gnt_o) r_done <= '0;
         else          r_done <= r_done | (out_req_o & out_gnt_i);
         unique case ({in_gnt_o, in_r_valid_o})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

`ifdef SFM_TCDM_LANE_SYNC_PERF_EN
   logic [31:0] r_perf;

   always_ff @(posedge clk_i) begin
      if (!rst_ni)                               r_perf <= '0;
      else if (perf_clr_i)                       r_perf <= '0;
      else if (in_req_i && !in_gnt_o && ~&r_perf) r_perf <= r_perf + 1'b1;
   end

   assign perf_stall_o = r_perf;
`else
   assign perf_stall_o = '0;
`endif

   assign w_unused = ^{w_full, perf_clr_i};

endmodule

// File: tb/tb_sfm_tcdm_lane_sync.sv
// Directed bench for sfm_tcdm_lane_sync (MP=4, DEPTH=2).
module tb_sfm_tcdm_lane_sync;

   localparam int MP = 4;
   localparam int DEPTH = 2;
`ifdef SFM_TCDM_LANE_SYNC_PERF_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 in_req;
   logic                 in_gnt;
   logic [MP-1:0][31:0]  in_add;
   logic                 in_wen;
   logic [MP-1:0][3:0]   in_be;
   logic [MP-1:0][31:0]  in_data;
   logic [MP-1:0][31:0]  in_r_data;
   logic                 in_r_valid;
   logic [MP-1:0]        out_req;
   logic [MP-1:0]        out_gnt;
   logic [MP-1:0][31:0]  out_add;
   logic [MP-1:0]        out_wen;
   logic [MP-1:0][3:0]   out_be;
   logic [MP-1:0][31:0]  out_data;
   logic [MP-1:0][31:0]  out_r_data;
   logic [MP-1:0]        out_r_valid;
   logic                 perf_clr;
   logic [31:0]          perf_stall;

   int npass = 0;
   int ntot  = 0;

   always #5 clk = ~clk;

   sfm_tcdm_lane_sync #(.MP(MP), .DEPTH(DEPTH)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .in_req_i      (in_req),
      .in_gnt_o      (in_gnt),
      .in_add_i      (in_add),
      .in_wen_i      (in_wen),
      .in_be_i       (in_be),
      .in_data_i     (in_data),
      .in_r_data_o   (in_r_data),
      .in_r_valid_o  (in_r_valid),
      .out_req_o     (out_req),
      .out_gnt_i     (out_gnt),
      .out_add_o     (out_add),
      .out_wen_o     (out_wen),
      .out_be_o      (out_be),
      .out_data_o    (out_data),
      .out_r_data_i  (out_r_data),
      .out_r_valid_i (out_r_valid),
      .perf_clr_i    (perf_clr),
      .perf_stall_o  (perf_stall)
   );

   task automatic ck(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   initial begin
      rst_n = 1'b0; in_req = 1'b0; in_wen = 1'b0;
      in_add = '0; in_be = '0; in_data = '0;
      out_gnt = '0; out_r_data = '0; out_r_valid = '0; perf_clr = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      ck("rst_gnt", in_gnt, 0);
      ck("rst_req", out_req, 0);
      ck("rst_rvalid", in_r_valid, 0);
      ck("rst_rdata", in_r_data, 0);
      ck("rst_perf", perf_stall, 0);

      // T1: single-cycle grant, single-cycle response
      @(negedge clk);
      rst_n = 1'b1; in_req = 1'b1; in_wen = 1'b1;
      in_add = {32'h100C, 32'h1008, 32'h1004, 32'h1000};
      in_be = {4'hF, 4'hF, 4'hF, 4'hF}; out_gnt = 4'b1111;
      #1;
      ck("t1_req", out_req, 4'b1111);
      ck("t1_gnt", in_gnt, 1);
      ck("t1_add", out_add, {32'h100C, 32'h1008, 32'h1004, 32'h1000});
      ck("t1_wen", out_wen, 4'b1111);
      @(negedge clk);
      in_req = 1'b0; out_gnt = '0; out_r_valid = 4'b1111;
      out_r_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      #1;
      ck("t1_rvalid", in_r_valid, 1);
      ck("t1_rdata", in_r_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      ck("t1_req_idle", out_req, 0);
      @(negedge clk);
      out_r_valid = '0;
      #1;
      ck("t1_rvalid_off", in_r_valid, 0);

      // T2/T3: lane 2 late grant, skewed responses
      @(negedge clk);
      in_req = 1'b1; out_gnt = 4'b1011;
      #1;
      ck("t2_c0_req", out_req, 4'b1111);
      ck("t2_c0_gnt", in_gnt, 0);
      @(negedge clk);
      out_gnt = '0; out_r_valid = 4'b0001;
      out_r_data = {32'hBAD, 32'hBAD, 32'hBAD, 32'hC0};
      #1;
      ck("t2_c1_req", out_req, 4'b0100);
      ck("t2_c1_gnt", in_gnt, 0);
      ck("t3_c1_rvalid", in_r_valid, 0);
      @(negedge clk);
      out_r_valid = 4'b0110;
      out_r_data = {32'hBAD, 32'hC2, 32'hC1, 32'hBAD};
      #1;
      ck("t2_c2_req", out_req, 4'b0100);
      ck("t3_c2_rvalid", in_r_valid, 0);
      @(negedge clk);
      out_gnt = 4'b0100; out_r_valid = '0;
      #1;
      ck("t2_c3_req", out_req, 4'b0100);
      ck("t2_c3_gnt", in_gnt, 1);
      ck("t3_c3_rvalid", in_r_valid, 0);
      @(negedge clk);
      in_req = 1'b0; out_gnt = '0; out_r_valid = 4'b1000;
      out_r_data = {32'hC3, 32'hBAD, 32'hBAD, 32'hBAD};
      #1;
      ck("t2_c4_req", out_req, 0);
      ck("t3_c4_rvalid", in_r_valid, 1);
      ck("t3_c4_rdata", in_r_data, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
      @(negedge clk);
      out_r_valid = '0;
      #1;
      ck("t3_c5_rvalid", in_r_valid, 0);

      // T4: DEPTH limit with withheld responses
      @(negedge clk);
      in_req = 1'b1; out_gnt = 4'b1111;
      #1;
      ck("t4_g1", in_gnt, 1);
      @(negedge clk);
      #1;
      ck("t4_g2", in_gnt, 1);
      @(negedge clk);
      #1;
      ck("t4_blk_req_a", out_req, 0);
      ck("t4_blk_gnt_a", in_gnt, 0);
      @(negedge clk);
      #1;
      ck("t4_blk_gnt_b", in_gnt, 0);
      @(negedge clk);
      out_r_valid = 4'b1111;
      out_r_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
      #1;
      ck("t4_r1_valid", in_r_valid, 1);
      ck("t4_r1_data", in_r_data, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
      ck("t4_r1_req", out_req, 0);
      ck("t4_r1_gnt", in_gnt, 0);
      @(negedge clk);
      out_r_valid = '0;
      #1;
      ck("t4_g3_req", out_req, 4'b1111);
      ck("t4_g3_gnt", in_gnt, 1);
      @(negedge clk);
      in_req = 1'b0; out_gnt = '0; out_r_valid = 4'b1111;
      out_r_data = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
      #1;
      ck("t4_r2_data", in_r_data, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
      @(negedge clk);
      out_r_data = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
      #1;
      ck("t4_r3_valid", in_r_valid, 1);
      ck("t4_r3_data", in_r_data, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
      @(negedge clk);
      out_r_valid = '0;
      #1;
      ck("t4_idle_valid", in_r_valid, 0);

      // T6: stall counter (six stalls so far, cleared here)
      @(negedge clk);
      ck("t6_pre_clr", perf_stall, PERF_ON ? 6 : 0);
      perf_clr = 1'b1;
      @(negedge clk);
      perf_clr = 1'b0; in_req = 1'b1; out_gnt = '0;
      #1;
      ck("t6_cleared", perf_stall, 0);
      repeat (4) @(negedge clk);
      @(negedge clk);
      out_gnt = 4'b1111;
      #1;
      ck("t6_five", perf_stall, PERF_ON ? 5 : 0);
      ck("t6_gnt", in_gnt, 1);

      // T5: reset with done=0011, cnt=1
      @(negedge clk);
      out_gnt = 4'b0011;
      #1;
      ck("t5_pre_gnt", in_gnt, 0);
      ck("t5_pre_req", out_req, 4'b1111);
      @(negedge clk);
      ck("t6_six", perf_stall, PERF_ON ? 6 : 0);
      rst_n = 1'b0; in_req = 1'b0; out_gnt = '0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      ck("t5_req", out_req, 0);
      ck("t5_rvalid", in_r_valid, 0);
      ck("t5_perf", perf_stall, 0);
      @(negedge clk);
      in_req = 1'b1;
      #1;
      ck("t5_done_clr", out_req, 4'b1111);
      @(negedge clk);
      out_gnt = 4'b1111;
      #1;
      ck("t5_cnt_g1", in_gnt, 1);
      @(negedge clk);
      #1;
      ck("t5_cnt_g2", in_gnt, 1);
      @(negedge clk);
      #1;
      ck("t5_cnt_full", out_req, 0);
      @(negedge clk);
      in_req = 1'b0; out_gnt = '0; out_r_valid = 4'b1111;
      out_r_data = {32'h93, 32'h92, 32'h91, 32'h90};
      #1;
      ck("t5_bypass", in_r_data, {32'h93, 32'h92, 32'h91, 32'h90});
      @(negedge clk);
      out_r_valid = '0;

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
